// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back selects, forwarding select encoding,
// and hazard FSM state type.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned PERF_CNT_W = 32;
  localparam int unsigned LU_CNT_W   = 2;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_SEL_MEM = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one Execute operand against the shadow M and W
// destinations; M wins over W, loads in M cannot forward, x0 never forwards.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr_m,
  input  logic                  rd_wren_m,
  input  logic                  load_m,
  input  logic [REG_ADDR_W-1:0] rd_addr_w,
  input  logic                  rd_wren_w,
  output fwd_sel_t              sel_c
);

  always_comb begin
    sel_c = FWD_REG;
    if (rd_wren_m && (rd_addr_m != '0) && (rd_addr_m == rs_addr) && !load_m) begin
      sel_c = FWD_M;
    end else if (rd_wren_w && (rd_addr_w != '0) && (rd_addr_w == rs_addr)) begin
      sel_c = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller at the D/E boundary: forwarding, load-use stall FSM and
// control flush. Define HAZARD_PERF_EN to enable the stall/flush perf counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr_D,
  input  logic [REG_ADDR_W-1:0] rs2_addr_D,
  input  logic [REG_ADDR_W-1:0] rs1_addr_E,
  input  logic [REG_ADDR_W-1:0] rs2_addr_E,
  input  logic [REG_ADDR_W-1:0] rd_addr_E,
  input  logic                  rd_wren_E,
  input  logic [WB_SEL_W-1:0]   wb_sel_E,
  input  logic                  pc_sel_E,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  // Extra bubbles beyond the first one, loaded when entering LU_STALL.
  localparam logic [LU_CNT_W-1:0] CNT_INIT =
    (LOAD_STALL_CYCLES > 1) ? LU_CNT_W'(LOAD_STALL_CYCLES - 2) : '0;

  logic [REG_ADDR_W-1:0] rd_addr_M, rd_addr_W;
  logic                  rd_wren_M, rd_wren_W, load_M;

  hz_state_t             state, state_nxt;
  logic [LU_CNT_W-1:0]   cnt, cnt_nxt;
  logic                  lu, stall, flush_d, flush_e;
  fwd_sel_t              fwd_a, fwd_b;

  // Shadow E->M->W destination pipeline; never stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_addr_M <= '0;
      rd_wren_M <= 1'b0;
      load_M    <= 1'b0;
      rd_addr_W <= '0;
      rd_wren_W <= 1'b0;
    end else begin
      rd_addr_M <= rd_addr_E;
      rd_wren_M <= rd_wren_E & ~FlushE;
      load_M    <= (wb_sel_E == WB_SEL_MEM);
      rd_addr_W <= rd_addr_M;
      rd_wren_W <= rd_wren_M;
    end
  end

  fwd_unit u_fwd_a (
    .rs_addr   (rs1_addr_E),
    .rd_addr_m (rd_addr_M),
    .rd_wren_m (rd_wren_M),
    .load_m    (load_M),
    .rd_addr_w (rd_addr_W),
    .rd_wren_w (rd_wren_W),
    .sel_c     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_addr   (rs2_addr_E),
    .rd_addr_m (rd_addr_M),
    .rd_wren_m (rd_wren_M),
    .load_m    (load_M),
    .rd_addr_w (rd_addr_W),
    .rd_wren_w (rd_wren_W),
    .sel_c     (fwd_b)
  );

  assign lu = (wb_sel_E == WB_SEL_MEM) && rd_wren_E && (rd_addr_E != '0) &&
              ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Priority: control flush > ongoing stall > new load-use > idle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (pc_sel_E) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        LU_STALL: begin
          stall   = 1'b1;
          flush_e = 1'b1;
          if (cnt == '0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - LU_CNT_W'(1);
          end
        end
        default: begin
          if (lu) begin
            stall   = 1'b1;
            flush_e = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = LU_STALL;
              cnt_nxt   = CNT_INIT;
            end
          end
        end
      endcase
    end
  end

  assign StallF    = stall & ~i_rst;
  assign StallD    = stall & ~i_rst;
  assign FlushD    = flush_d & ~i_rst;
  assign FlushE    = flush_e & ~i_rst;
  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_q, flush_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (StallD) stall_q <= stall_q + PERF_CNT_W'(1);
      if (pc_sel_E) flush_q <= flush_q + PERF_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
